// File: rtl/lfsr_seq_ctrl.sv
// Command sequencer for the 8-bit LFSR display: LOAD/STEP/RUN/STOP, done/err one cycle after the edge.
// cmd_ready is low only while a STEP burst runs; commands other than STOP are dropped with err during RUN.
module lfsr_seq_ctrl #(
    parameter int DIV   = 1000,
    parameter int DIV_W = $clog2(DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_arg,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic [7:0]       lfsr_q,
    output logic [6:0]       SEG1,
    output logic [6:0]       SEG0
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_STEP = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_STOP = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       rem;
    logic [DIV_W-1:0] pre;
    logic [7:0]       lfsr_nxt;
    logic             pre_wrap;

    assign lfsr_nxt  = {lfsr_q[4] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0], lfsr_q[7:1]};
    assign pre_wrap  = (pre == DIV_W'(DIV - 1));
    assign cmd_ready = (state == IDLE) || (state == RUN);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            lfsr_q <= 8'h01;
            rem    <= 8'd0;
            pre    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_LOAD: begin
                                // zero would lock the LFSR, so it is replaced by 1
                                lfsr_q <= (cmd_arg == 8'h00) ? 8'h01 : cmd_arg;
                                done   <= 1'b1;
                            end
                            OP_STEP: begin
                                if (cmd_arg == 8'd0) begin
                                    done <= 1'b1;
                                end else begin
                                    rem   <= cmd_arg;
                                    state <= STEP;
                                end
                            end
                            OP_RUN: begin
                                pre   <= '0;
                                state <= RUN;
                            end
                            default: done <= 1'b1;
                        endcase
                    end
                end
                STEP: begin
                    lfsr_q <= lfsr_nxt;
                    rem    <= rem - 8'd1;
                    if (rem == 8'd1) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                RUN: begin
                    if (cmd_valid && (cmd_op == OP_STOP)) begin
                        // STOP wins over a coincident prescaler wrap: no shift on this edge
                        state <= IDLE;
                        done  <= 1'b1;
                        pre   <= '0;
                    end else begin
                        if (cmd_valid) begin
                            err <= 1'b1;
                        end
                        if (pre_wrap) begin
                            lfsr_q <= lfsr_nxt;
                            pre    <= '0;
                        end else begin
                            pre <= pre + DIV_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

    assign SEG1 = seg7(lfsr_q[7:4]);
    assign SEG0 = seg7(lfsr_q[3:0]);

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with DIV=4: vector table plus STEP-backpressure and mid-STEP reset sequences.
module tb_lfsr_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       done;
    logic       err;
    logic       busy;
    logic [7:0] lfsr_q;
    logic [6:0] SEG1;
    logic [6:0] SEG0;

    int checks = 0;
    int errors = 0;

    lfsr_seq_ctrl #(.DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .lfsr_q    (lfsr_q),
        .SEG1      (SEG1),
        .SEG0      (SEG0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [1:0] op;
        logic [7:0] arg;
        logic       rdy;
        logic       dn;
        logic       er;
        logic       bsy;
        logic [7:0] q;
        logic [6:0] s1;
        logic [6:0] s0;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic vld, logic [1:0] op, logic [7:0] arg,
                               logic rdy, logic dn, logic er, logic bsy,
                               logic [7:0] q, logic [6:0] s1, logic [6:0] s0);
        vec_t r;
        r.vld = vld; r.op = op; r.arg = arg;
        r.rdy = rdy; r.dn = dn; r.er = er; r.bsy = bsy;
        r.q = q; r.s1 = s1; r.s0 = s0;
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [1:0] op, input logic [7:0] arg);
        cmd_valid = vld;
        cmd_op    = op;
        cmd_arg   = arg;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 2'b00, 8'h00);

        // vectors: inputs for the next edge, outputs expected just after it (DIV=4)
        vecs.push_back(v(1, 2'd1, 8'h03, 0, 0, 0, 1, 8'h01, 7'h01, 7'h4F)); // STEP 3
        vecs.push_back(v(0, 2'd0, 8'h00, 0, 0, 0, 1, 8'h80, 7'h00, 7'h01));
        vecs.push_back(v(0, 2'd0, 8'h00, 0, 0, 0, 1, 8'h40, 7'h4C, 7'h01));
        vecs.push_back(v(0, 2'd0, 8'h00, 1, 1, 0, 0, 8'h20, 7'h12, 7'h01));
        vecs.push_back(v(0, 2'd0, 8'h00, 1, 0, 0, 0, 8'h20, 7'h12, 7'h01));
        vecs.push_back(v(1, 2'd0, 8'hA5, 1, 1, 0, 0, 8'hA5, 7'h08, 7'h24)); // LOAD A5
        vecs.push_back(v(1, 2'd1, 8'h01, 0, 0, 0, 1, 8'hA5, 7'h08, 7'h24)); // STEP 1
        vecs.push_back(v(0, 2'd0, 8'h00, 1, 1, 0, 0, 8'h52, 7'h24, 7'h12));
        vecs.push_back(v(1, 2'd0, 8'h00, 1, 1, 0, 0, 8'h01, 7'h01, 7'h4F)); // LOAD 00
        vecs.push_back(v(1, 2'd0, 8'h20, 1, 1, 0, 0, 8'h20, 7'h12, 7'h01)); // back-to-back LOAD
        vecs.push_back(v(1, 2'd0, 8'h01, 1, 1, 0, 0, 8'h01, 7'h01, 7'h4F));
        vecs.push_back(v(1, 2'd3, 8'h00, 1, 1, 0, 0, 8'h01, 7'h01, 7'h4F)); // STOP in IDLE
        vecs.push_back(v(1, 2'd1, 8'h00, 1, 1, 0, 0, 8'h01, 7'h01, 7'h4F)); // STEP 0
        vecs.push_back(v(1, 2'd2, 8'h00, 1, 0, 0, 1, 8'h01, 7'h01, 7'h4F)); // RUN, pre=0
        vecs.push_back(v(0, 2'd0, 8'h00, 1, 0, 0, 1, 8'h01, 7'h01, 7'h4F));
        vecs.push_back(v(0, 2'd0, 8'h00, 1, 0, 0, 1, 8'h01, 7'h01, 7'h4F));
        vecs.push_back(v(0, 2'd0, 8'h00, 1, 0, 0, 1, 8'h01, 7'h01, 7'h4F));
        vecs.push_back(v(0, 2'd0, 8'h00, 1, 0, 0, 1, 8'h80, 7'h00, 7'h01)); // edge k+4
        vecs.push_back(v(1, 2'd0, 8'h33, 1, 0, 1, 1, 8'h80, 7'h00, 7'h01)); // LOAD in RUN
        vecs.push_back(v(0, 2'd0, 8'h00, 1, 0, 0, 1, 8'h80, 7'h00, 7'h01));
        vecs.push_back(v(0, 2'd0, 8'h00, 1, 0, 0, 1, 8'h80, 7'h00, 7'h01));
        vecs.push_back(v(0, 2'd0, 8'h00, 1, 0, 0, 1, 8'h40, 7'h4C, 7'h01)); // edge k+8
        vecs.push_back(v(1, 2'd1, 8'h02, 1, 0, 1, 1, 8'h40, 7'h4C, 7'h01)); // STEP in RUN
        vecs.push_back(v(1, 2'd2, 8'h00, 1, 0, 1, 1, 8'h40, 7'h4C, 7'h01)); // RUN in RUN
        vecs.push_back(v(0, 2'd0, 8'h00, 1, 0, 0, 1, 8'h40, 7'h4C, 7'h01));
        vecs.push_back(v(1, 2'd3, 8'h00, 1, 1, 0, 0, 8'h40, 7'h4C, 7'h01)); // STOP on wrap edge
        vecs.push_back(v(0, 2'd0, 8'h00, 1, 0, 0, 0, 8'h40, 7'h4C, 7'h01));

        // reset state
        repeat (2) @(posedge clk);
        #3;
        check("rst_lfsr", lfsr_q, 8'h01);
        check("rst_seg1", {1'b0, SEG1}, 8'h01);
        check("rst_seg0", {1'b0, SEG0}, 8'h4F);
        check("rst_ready", {7'd0, cmd_ready}, 8'd1);
        check("rst_busy", {7'd0, busy}, 8'd0);
        rst = 1'b1;
        tick();
        check("idle_done", {7'd0, done}, 8'd0);
        check("idle_err", {7'd0, err}, 8'd0);
        check("idle_lfsr", lfsr_q, 8'h01);

        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].op, vecs[i].arg);
            tick();
            check($sformatf("v%0d_ready", i), {7'd0, cmd_ready}, {7'd0, vecs[i].rdy});
            check($sformatf("v%0d_done", i), {7'd0, done}, {7'd0, vecs[i].dn});
            check($sformatf("v%0d_err", i), {7'd0, err}, {7'd0, vecs[i].er});
            check($sformatf("v%0d_busy", i), {7'd0, busy}, {7'd0, vecs[i].bsy});
            check($sformatf("v%0d_lfsr", i), lfsr_q, vecs[i].q);
            check($sformatf("v%0d_seg1", i), {1'b0, SEG1}, {1'b0, vecs[i].s1});
            check($sformatf("v%0d_seg0", i), {1'b0, SEG0}, {1'b0, vecs[i].s0});
        end

        // STEP 5 from 40 with a LOAD held valid behind it
        drive(1'b1, 2'd1, 8'h05);
        tick();
        drive(1'b1, 2'd0, 8'h77);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("s5_ready_low%0d", c), {7'd0, cmd_ready}, 8'd0);
            check($sformatf("s5_done_low%0d", c), {7'd0, done}, 8'd0);
            tick();
        end
        check("s5_ready_back", {7'd0, cmd_ready}, 8'd1);
        check("s5_done", {7'd0, done}, 8'd1);
        check("s5_lfsr", lfsr_q, 8'hE2);
        tick();
        check("s5_load_acc", lfsr_q, 8'h77);
        check("s5_load_done", {7'd0, done}, 8'd1);
        drive(1'b0, 2'd0, 8'h00);

        // asynchronous reset in the middle of STEP 200
        drive(1'b1, 2'd1, 8'd200);
        tick();
        drive(1'b0, 2'd0, 8'h00);
        repeat (3) tick();
        check("mid_busy", {7'd0, busy}, 8'd1);
        check("mid_lfsr_moved", {7'd0, lfsr_q != 8'h77}, 8'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_lfsr", lfsr_q, 8'h01);
        check("arst_busy", {7'd0, busy}, 8'd0);
        check("arst_ready", {7'd0, cmd_ready}, 8'd1);
        check("arst_done", {7'd0, done}, 8'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("post_rst_done%0d", c), {7'd0, done}, 8'd0);
            check($sformatf("post_rst_lfsr%0d", c), lfsr_q, 8'h01);
        end
        drive(1'b1, 2'd1, 8'h00);
        tick();
        drive(1'b0, 2'd0, 8'h00);
        check("step0_done", {7'd0, done}, 8'd1);
        check("step0_lfsr", lfsr_q, 8'h01);
        check("step0_busy", {7'd0, busy}, 8'd0);
        tick();
        check("step0_done_clr", {7'd0, done}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
